// File: rtl/icache_dm_if.sv
// Fetch-side and refill-side signals of the direct-mapped instruction cache.
interface icache_dm_if;
  logic [31:0] pc;
  logic        req;
  logic        flush;
  logic        rdy;
  logic [31:0] instr;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_data;

  // Cache side.
  modport slave (
    input  pc, req, flush, mem_ack, mem_data,
    output rdy, instr, mem_req, mem_addr
  );

  // Fetch stage together with the backing memory.
  modport master (
    output pc, req, flush, mem_ack, mem_data,
    input  rdy, instr, mem_req, mem_addr
  );
endinterface

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache: same-cycle hits, line refill over a word-wide
// req/ack port, and whole-cache invalidate for fence.i.
module icache_dm #(
  parameter int unsigned LINES = 16,
  parameter int unsigned WORDS = 4
) (
  input logic        clk,
  input logic        rst,
  icache_dm_if.slave bus
);
  localparam int unsigned OFF_W  = $clog2(WORDS);
  localparam int unsigned IDX_W  = $clog2(LINES);
  localparam int unsigned TAG_W  = 30 - OFF_W - IDX_W;
  localparam int unsigned DA_W   = OFF_W + IDX_W;
  localparam int unsigned BEAT_W = (OFF_W > 0) ? OFF_W : 1;
  localparam int unsigned LINE_W = 30 - OFF_W;
  localparam logic [31:0] LINE_MASK = ~(32'(WORDS * 4) - 32'd1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS - 1);

  typedef enum logic [1:0] {StIdle, StRefill, StFlush} state_e;

  state_e state_q, state_d;

  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [31:0]       data_q [LINES*WORDS];
  // Tag and index of the line being refilled.
  logic [LINE_W-1:0] line_q;
  logic [BEAT_W-1:0] beat_q;
  logic              flush_pending_q;
  logic              mem_req_q;
  logic [31:0]       mem_addr_q;

  logic [IDX_W-1:0] pc_idx, fill_idx;
  logic [TAG_W-1:0] pc_tag, fill_tag;
  logic [DA_W-1:0]  rd_addr, wr_addr;
  logic             hit, start_fill, beat_ack, last_ack;

  assign pc_idx   = bus.pc[2+OFF_W +: IDX_W];
  assign pc_tag   = bus.pc[2+DA_W +: TAG_W];
  assign rd_addr  = bus.pc[2 +: DA_W];
  assign fill_idx = line_q[IDX_W-1:0];
  assign fill_tag = line_q[IDX_W +: TAG_W];
  assign wr_addr  = (DA_W'(fill_idx) << OFF_W) | DA_W'(beat_q);

  assign hit        = valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);
  assign start_fill = (state_q == StIdle) && !bus.flush && bus.req && !hit;
  // mem_req is high for the whole of StRefill, so acks outside it are ignored.
  assign beat_ack   = (state_q == StRefill) && bus.mem_ack;
  assign last_ack   = beat_ack && (beat_q == LAST_BEAT);

  assign bus.mem_req  = mem_req_q;
  assign bus.mem_addr = mem_addr_q;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state logic; flush wins over a miss in idle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (bus.flush)       state_d = StFlush;
        else if (start_fill) state_d = StRefill;
      end
      StRefill: if (last_ack) state_d = StIdle;
      StFlush:  state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Lookup outputs; instr is forced to zero unless it is valid for pc.
  always_comb begin
    bus.rdy   = (state_q == StIdle) && bus.req && hit && !bus.flush;
    bus.instr = bus.rdy ? data_q[rd_addr] : 32'd0;
  end

  // Refill sequencing: latch the line, step beat and address on each ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_q          <= '0;
      beat_q          <= '0;
      mem_req_q       <= 1'b0;
      mem_addr_q      <= 32'd0;
      flush_pending_q <= 1'b0;
    end else begin
      if (start_fill) begin
        line_q     <= bus.pc[31:2+OFF_W];
        beat_q     <= '0;
        mem_req_q  <= 1'b1;
        mem_addr_q <= bus.pc & LINE_MASK;
      end else if (beat_ack) begin
        beat_q     <= beat_q + 1'b1;
        mem_addr_q <= mem_addr_q + 32'd4;
        if (last_ack) mem_req_q <= 1'b0;
      end
      if (state_q == StRefill) begin
        flush_pending_q <= last_ack ? 1'b0 : (flush_pending_q | bus.flush);
      end
    end
  end

  // Valid bits: a flush seen during refill discards the line and clears all.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (state_q == StFlush) begin
      valid_q <= '0;
    end else if (last_ack) begin
      if (flush_pending_q || bus.flush) valid_q <= '0;
      else                              valid_q[fill_idx] <= 1'b1;
    end
  end

  // Tag and data arrays; contents are meaningless until the valid bit is set.
  always_ff @(posedge clk) begin
    if (beat_ack) data_q[wr_addr] <= bus.mem_data;
    if (last_ack) tag_q[fill_idx] <= fill_tag;
  end
endmodule

// File: tb/tb_icache_dm.sv
// Scoreboard bench for icache_dm: backing memory returns word == address, a
// line-level valid/tag model predicts hits, misses and refill beat addresses.
module tb_icache_dm;
  localparam int unsigned L = 16;
  localparam int unsigned W = 4;

  typedef struct {
    logic [31:0] instr;
    bit          miss;
    int          lat;
    int          issue;
  } exp_t;

  logic clk;
  logic rst;
  icache_dm_if bus ();

  icache_dm #(.LINES(L), .WORDS(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t        eq[$];
  logic [31:0] mq[$];
  int          ncmp = 0;
  int          nfail = 0;
  int          cyc = 0;
  int          last_ack = 0;
  int          acks = 0;
  int          done_cnt = 0;
  int          ack_mode = 0;
  bit          started = 0;
  bit          mv[L];
  int unsigned mt[L];

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic int unsigned idx_of(input logic [31:0] a);
    return (a / (4 * W)) % L;
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] a);
    return a / (4 * W * L);
  endfunction

  function automatic logic [31:0] base_of(input logic [31:0] a);
    return a - (a % (4 * W));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_clear();
    foreach (mv[i]) mv[i] = 0;
  endtask

  // Backing memory: word == address, ack pattern chosen by ack_mode.
  initial begin
    bus.mem_ack  = 0;
    bus.mem_data = 0;
    forever begin
      @(posedge clk);
      #1;
      case (ack_mode)
        0:       bus.mem_ack = 1'b1;
        1:       bus.mem_ack = (cyc % 3 == 0);
        default: bus.mem_ack = 1'($urandom_range(0, 1));
      endcase
      bus.mem_data = bus.mem_addr;
    end
  end

  // Monitor: refill beats against the beat queue, fetch results against the scoreboard.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!rst) begin
      if (bus.mem_req) begin
        if (mq.size() == 0) begin
          ncmp++;
          nfail++;
          $display("FAIL mem_req_spurious: got mem_req=1 addr=%h, expected mem_req=0", bus.mem_addr);
        end else begin
          chk("mem_addr", bus.mem_addr, mq[0]);
          started = 1;
          if (bus.mem_ack) begin
            void'(mq.pop_front());
            last_ack = cyc;
            acks++;
            if (mq.size() == 0) started = 0;
          end
        end
      end else if (started) begin
        chk("mem_req_held", 32'(bus.mem_req), 32'd1);
      end

      if (bus.rdy) begin
        if (eq.size() == 0) begin
          ncmp++;
          nfail++;
          $display("FAIL rdy_spurious: got rdy=1 pc=%h, expected rdy=0", bus.pc);
        end else begin
          e = eq.pop_front();
          chk("instr", bus.instr, e.instr);
          if (e.miss) begin
            chk("rdy_after_last_ack", 32'(cyc), 32'(last_ack + 1));
            if (e.lat >= 0) chk("miss_latency", 32'(cyc - e.issue), 32'(e.lat));
          end else begin
            chk("hit_latency", 32'(cyc - e.issue), 32'd0);
          end
          done_cnt++;
        end
      end else begin
        chk("instr_zero", bus.instr, 32'd0);
      end
    end
  end

  // All driver tasks start and end just after a rising edge.
  task automatic fetch(input logic [31:0] a);
    exp_t        e;
    int unsigned i;
    int          t;
    int          d0;
    i       = idx_of(a);
    e.instr = a & 32'hFFFF_FFFC;
    e.issue = cyc;
    e.miss  = !(mv[i] && mt[i] == tag_of(a));
    e.lat   = (ack_mode == 0) ? int'(W) + 1 : -1;
    if (e.miss) begin
      for (int w = 0; w < int'(W); w++) mq.push_back(base_of(a) + 32'(4 * w));
      mv[i] = 1;
      mt[i] = tag_of(a);
    end
    d0 = done_cnt;
    eq.push_back(e);
    bus.pc  = a;
    bus.req = 1;
    t = 0;
    while (done_cnt == d0 && t < 300) begin
      @(posedge clk);
      #1;
      t++;
    end
    bus.req = 0;
    if (done_cnt == d0) begin
      ncmp++;
      nfail++;
      $display("FAIL fetch_timeout: got no rdy for pc=%h, expected rdy within 300 cycles", a);
      eq.delete();
      mq.delete();
      started = 0;
    end
  endtask

  // One-cycle request that starts a refill nobody waits for.
  task automatic start_refill(input logic [31:0] a);
    for (int w = 0; w < int'(W); w++) mq.push_back(base_of(a) + 32'(4 * w));
    mv[idx_of(a)] = 1;
    mt[idx_of(a)] = tag_of(a);
    bus.pc  = a;
    bus.req = 1;
    @(posedge clk);
    #1;
    bus.req = 0;
  endtask

  // Flush in idle with a request held: no rdy in the flush cycle nor the dead cycle.
  task automatic flush_idle(input logic [31:0] a);
    bus.pc    = a;
    bus.req   = 1;
    bus.flush = 1;
    model_clear();
    @(negedge clk);
    chk("flush_cycle_rdy", 32'(bus.rdy), 32'd0);
    @(posedge clk);
    #1;
    bus.flush = 0;
    @(negedge clk);
    chk("flush_dead_rdy", 32'(bus.rdy), 32'd0);
    @(posedge clk);
    #1;
    bus.req = 0;
  endtask

  initial begin
    int          t;
    int          a0;
    logic [31:0] a;
    rst       = 1;
    bus.pc    = 32'h40;
    bus.req   = 1;
    bus.flush = 0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rdy", 32'(bus.rdy), 32'd0);
    chk("reset_instr", bus.instr, 32'd0);
    chk("reset_mem_req", 32'(bus.mem_req), 32'd0);
    chk("reset_mem_addr", bus.mem_addr, 32'd0);
    bus.req = 0;
    rst = 0;
    @(posedge clk);
    #1;

    // Cold miss, then hits in the same line.
    ack_mode = 0;
    fetch(32'h40);
    fetch(32'h44);
    fetch(32'h48);
    fetch(32'h4C);

    // Conflicting lines evict each other.
    fetch(32'h140);
    fetch(32'h40);

    // Wait states: ack every third cycle.
    ack_mode = 1;
    fetch(32'h80);
    fetch(32'h84);

    // Flush in idle, then the filled line misses.
    ack_mode = 0;
    flush_idle(32'h40);
    fetch(32'h40);

    // Flush during refill: the line completes but stays invalid.
    ack_mode = 1;
    start_refill(32'h80);
    bus.flush = 1;
    @(posedge clk);
    #1;
    bus.flush = 0;
    model_clear();
    t = 0;
    while (mq.size() > 0 && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("flush_refill_done", 32'(mq.size()), 32'd0);
    @(posedge clk);
    #1;
    fetch(32'h80);

    // Reset after two beats of a refill.
    ack_mode = 0;
    a0 = acks;
    start_refill(32'h1C0);
    t = 0;
    while (acks < a0 + 2 && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    bus.pc  = 32'h40;
    bus.req = 1;
    rst     = 1;
    #1;
    chk("midreset_mem_req", 32'(bus.mem_req), 32'd0);
    chk("midreset_rdy", 32'(bus.rdy), 32'd0);
    chk("midreset_instr", bus.instr, 32'd0);
    mq.delete();
    eq.delete();
    started = 0;
    model_clear();
    @(posedge clk);
    #1;
    bus.req = 0;
    rst = 0;
    @(posedge clk);
    #1;
    fetch(32'h40);
    fetch(32'h1C0);

    // Random fetches over a few conflicting lines, with occasional flushes.
    for (int it = 0; it < 160; it++) begin
      if (it % 40 == 0) ack_mode = $urandom_range(0, 2);
      a = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 3)) << 4) |
          (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) flush_idle(a);
      else                           fetch(a);
    end

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule

// File: doc/icache_dm.md
# icache_dm

Direct-mapped, parametrised instruction cache between the PC/fetch stage and the instruction memory of the RV32I core. It serves fetches from PC in the same cycle on a hit. On a miss it refills a full line from a slower word-wide backing memory through a req/ack handshake. It also supports a whole-cache invalidate for `fence.i`.

## Interface

Parameters:
- `LINES`, 16, number of cache lines; power of two, ≥2.
- `WORDS`, 4, 32-bit words per line; power of two, ≥1.
- Derived: `OFF_W = log2(WORDS)`, `IDX_W = log2(LINES)`, `TAG_W = 30 - OFF_W - IDX_W`.

Ports:
- `clk` in 1: sole clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `pc` in 32: fetch address; bits [1:0] ignored.
- `req` in 1: fetch request valid.
- `flush` in 1: invalidate-all request, sampled on the rising edge.
- `rdy` out 1: `instr` is valid for the current `pc` (combinational).
- `instr` out 32: fetched instruction; 0 whenever `rdy`=0.
- `mem_req` out 1: refill beat request (registered).
- `mem_addr` out 32: word-aligned refill beat address (registered).
- `mem_ack` in 1: beat accepted; `mem_data` valid this cycle.
- `mem_data` in 32: refill data.

## Operation

- Address split: word offset `pc[2+OFF_W-1:2]`, index `pc[2+OFF_W+IDX_W-1:2+OFF_W]`, tag = remaining upper bits.
- Storage: `valid[LINES]` flop vector; tag array; data array of `LINES*WORDS` words. Arrays read asynchronously.
- State machine with three states:
  - IDLE: `hit = valid[idx] && tag[idx]==pc_tag`; `rdy = req && hit && !flush`.
    - If `flush`=1: go to FLUSH. Flush takes priority over a miss.
    - Else if `req && !hit`: latch line base `{pc[31:2+OFF_W], 0}`, set beat=0, drive `mem_req`=1 and `mem_addr`=base, go to REFILL.
  - REFILL: `rdy`=0.
    - On each cycle with `mem_ack`=1: write `mem_data` to word `beat` of the latched index and increment beat. `mem_addr` advances to base+4*beat for the next beat.
    - On the ack of beat `WORDS-1`: drop `mem_req`, write the tag, and set `valid[idx]`=1 unless a flush is pending; go to IDLE.
    - `pc`/`req` changes during REFILL are ignored; the latched line completes.
  - FLUSH: clear all `valid` bits; `rdy`=0; go to IDLE next cycle.
- `flush` asserted during REFILL sets `flush_pending`. At refill end, the line is not validated, all `valid` bits clear, `flush_pending` clears, and the state goes to IDLE.
- `mem_ack` while `mem_req`=0 is ignored.
- Conflicting lines with the same index evict each other (direct-mapped). There is no replacement state.

## Timing

- Reset values: state IDLE, all `valid`=0, `flush_pending`=0, beat=0, `mem_req`=0, `mem_addr`=0. Consequently `rdy`=0 and `instr`=0.
- Hit latency: 0 cycles (`rdy` in the same cycle that `pc`/`req` are presented).
- Miss, miss-detect cycle N: `mem_req`=1 from edge N+1. With `mem_ack` tied high, the final beat is accepted in cycle N+WORDS and `rdy`=1 in cycle N+WORDS+1. Each cycle of ack wait states adds one cycle.
- `mem_req` stays high continuously through all beats of a refill. `mem_addr` is stable until acked.
- Flush in IDLE: one dead cycle, then every lookup misses.
- `rst` asserted mid-refill: immediate return to reset values. The partially written line remains invalid.

## Test plan

- Cold miss, `LINES`=16, `WORDS`=4, `mem_ack` high, memory returns word = address: `pc`=0x40 → `mem_addr` 0x40, 0x44, 0x48, 0x4C on consecutive cycles. Then `rdy`=1 and `instr`=0x40 in the 5th cycle after detect.
- Line hit: after the previous case, `pc`=0x44, 0x48, 0x4C → `rdy`=1 in the same cycle with `instr` = `pc`, and `mem_req` stays 0.
- Conflict: fetch 0x40 then 0x140 (same index, different tag) → refill of 0x140..0x14C. Refetch 0x40 → miss and refill again.
- Wait states: `mem_ack` high every 3rd cycle on a miss at 0x80 → each `mem_addr` is held until acked. `rdy` rises one cycle after the 4th ack, with `instr`=0x80.
- Flush: flush in IDLE after filling 0x40 → `rdy`=0 for one cycle, then fetch 0x40 misses. Flush during refill of 0x80 → refill completes, 0x80 is not valid afterwards, and a refetch misses.
- Reset mid-refill after 2 beats → `mem_req`=0 and `rdy`=0 immediately. Fetch 0x40 after release → full 4-beat refill from 0x40.
